// File: rtl/fp_mult_pipe.sv
// Pipelined FP multiplier (RNE, flush-to-zero, IEEE-style flags): 3-cycle latency, one product per clock.
// A single enable (!out_valid | out_ready) advances or freezes every stage together; in_ready mirrors it.
module fp_mult_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  logic en;
  logic v0_q, v1_q, v2_q, out_valid_q;
  logic [W-1:0] a0_q, b0_q;
  logic [W-1:0] result_q;
  logic [3:0]   flags_q;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // S1: unpack, classify, exponent sum, mantissa multiply
  logic sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic s1_sign_d, s1_nan_d, s1_inv_d, s1_inf_d, s1_zero_d;
  logic [EW-1:0] s1_exp_d;
  logic [PW-1:0] s1_prod_d;

  assign {sa, ea, fa} = a0_q;
  assign {sb, eb, fb} = b0_q;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  assign s1_sign_d = sa ^ sb;
  assign s1_inv_d  = (a_inf && b_zero) || (a_zero && b_inf);
  assign s1_nan_d  = a_nan || b_nan || s1_inv_d;
  assign s1_inf_d  = a_inf || b_inf;
  assign s1_zero_d = a_zero || b_zero;
  assign s1_exp_d  = EW'(ea) + EW'(eb) - BIAS;
  assign s1_prod_d = PW'({1'b1, fa}) * PW'({1'b1, fb});

  logic s1_sign_q, s1_nan_q, s1_inv_q, s1_inf_q, s1_zero_q;
  logic [EW-1:0] s1_exp_q;
  logic [PW-1:0] s1_prod_q;

  // S2: normalise so the leading one sits just above the kept fraction, then RNE
  logic [PW-2:0]    norm;
  logic [MAN_W-1:0] frac_t;
  logic             guard, sticky, inc;
  logic [MAN_W+1:0] rsum;
  logic [EW-1:0]    e_n;
  logic [MAN_W-1:0] s2_frac_d;
  logic [EW-1:0]    s2_exp_d;
  logic             s2_inexact_d;

  assign norm   = s1_prod_q[PW-1] ? s1_prod_q[PW-2:0] : {s1_prod_q[PW-3:0], 1'b0};
  assign e_n    = s1_exp_q + EW'(s1_prod_q[PW-1]);
  assign frac_t = norm[PW-2 -: MAN_W];
  assign guard  = norm[PW-2-MAN_W];
  assign sticky = |norm[PW-3-MAN_W:0];
  assign inc    = guard && (sticky || frac_t[0]);
  assign rsum   = {1'b0, 1'b1, frac_t} + (MAN_W + 2)'(inc);

  assign s2_frac_d    = rsum[MAN_W+1] ? rsum[MAN_W:1] : rsum[MAN_W-1:0];
  assign s2_exp_d     = e_n + EW'(rsum[MAN_W+1]);
  assign s2_inexact_d = guard || sticky;

  logic s2_sign_q, s2_nan_q, s2_inv_q, s2_inf_q, s2_zero_q, s2_inexact_q;
  logic [EW-1:0]    s2_exp_q;
  logic [MAN_W-1:0] s2_frac_q;

  // S3: range check, special-case select, pack
  logic ovf, unf;
  logic [W-1:0] res_d;
  logic [3:0]   flg_d;

  assign ovf = $signed(s2_exp_q) >= $signed(EMAX);
  assign unf = $signed(s2_exp_q) <= $signed(EW'(0));

  always_comb begin
    res_d = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_frac_q};
    flg_d = {3'b000, s2_inexact_q};
    if (s2_nan_q) begin
      res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
      flg_d = {s2_inv_q, 3'b000};
    end else if (s2_inf_q) begin
      res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d = 4'b0000;
    end else if (s2_zero_q) begin
      res_d = {s2_sign_q, {(EXP_W + MAN_W){1'b0}}};
      flg_d = 4'b0000;
    end else if (ovf) begin
      res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d = 4'b0101;
    end else if (unf) begin
      res_d = {s2_sign_q, {(EXP_W + MAN_W){1'b0}}};
      flg_d = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (en) begin
      v0_q        <= in_valid;
      v1_q        <= v0_q;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (v2_q) begin
        result_q <= res_d;
        flags_q  <= flg_d;
      end
    end
  end

  // Datapath registers carry no reset; their contents only matter under a set valid bit.
  always_ff @(posedge clk) begin
    if (en) begin
      a0_q         <= a;
      b0_q         <= b;
      s1_sign_q    <= s1_sign_d;
      s1_nan_q     <= s1_nan_d;
      s1_inv_q     <= s1_inv_d;
      s1_inf_q     <= s1_inf_d;
      s1_zero_q    <= s1_zero_d;
      s1_exp_q     <= s1_exp_d;
      s1_prod_q    <= s1_prod_d;
      s2_sign_q    <= s1_sign_q;
      s2_nan_q     <= s1_nan_q;
      s2_inv_q     <= s1_inv_q;
      s2_inf_q     <= s1_inf_q;
      s2_zero_q    <= s1_zero_q;
      s2_exp_q     <= s2_exp_d;
      s2_frac_q    <= s2_frac_d;
      s2_inexact_q <= s2_inexact_d;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: single and half precision instances, scoreboard of expected {flags, result}.
module tb_fp_mult_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, in_ready, out_valid;
  logic [31:0] a, b, result;
  logic [3:0]  flags;
  logic        in_valid_h, out_ready_h, in_ready_h, out_valid_h;
  logic [15:0] a_h, b_h, result_h;
  logic [3:0]  flags_h;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid_h), .in_ready(in_ready_h), .a(a_h), .b(b_h),
    .out_valid(out_valid_h), .out_ready(out_ready_h), .result(result_h), .flags(flags_h)
  );

  int checks = 0;
  int errors = 0;
  int n_out = 0;
  int n_out_h = 0;
  logic [35:0] exp_in;
  logic [19:0] exp_h;
  logic [35:0] sb[$];
  logic [19:0] sbh[$];
  logic [35:0] pop_e;
  logic [19:0] pop_h;

  logic [31:0] va[8], vb[8], vr[8];
  logic [3:0]  vf[8];

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Push on accepted input; a reset edge discards everything in flight.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      sbh.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back(exp_in);
      if (in_valid_h && in_ready_h) sbh.push_back(exp_h);
    end
  end

  // Pop and compare for each output transfer that the coming edge will perform.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      chk("sb32_nonempty", 36'(sb.size() != 0), 36'd1);
      if (sb.size() != 0) begin
        pop_e = sb.pop_front();
        chk("result32", 36'(result), 36'(pop_e[31:0]));
        chk("flags32", 36'(flags), 36'(pop_e[35:32]));
      end
    end
    if (!rst && out_valid_h && out_ready_h) begin
      n_out_h++;
      chk("sb16_nonempty", 36'(sbh.size() != 0), 36'd1);
      if (sbh.size() != 0) begin
        pop_h = sbh.pop_front();
        chk("result16", 36'(result_h), 36'(pop_h[15:0]));
        chk("flags16", 36'(flags_h), 36'(pop_h[19:16]));
      end
    end
  end

  task automatic send(input logic [31:0] aa, input logic [31:0] bb, input logic [35:0] e);
    bit acc = 1'b0;
    a = aa;
    b = bb;
    exp_in = e;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", 36'(acc), 36'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sb.size() != 0 || sbh.size() != 0 || out_valid || out_valid_h); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain32", 36'(sb.size()), 36'd0);
    chk("drain16", 36'(sbh.size()), 36'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    va[0] = 32'h4048F5C3; vb[0] = 32'h40A00000; vr[0] = 32'h417B3334; vf[0] = 4'b0001;
    va[1] = 32'h4048F5C3; vb[1] = 32'hC0A00000; vr[1] = 32'hC17B3334; vf[1] = 4'b0001;
    va[2] = 32'hC048F5C3; vb[2] = 32'hC0A00000; vr[2] = 32'h417B3334; vf[2] = 4'b0001;
    va[3] = 32'h3F800001; vb[3] = 32'h3FC00000; vr[3] = 32'h3FC00002; vf[3] = 4'b0001;
    va[4] = 32'h7F000000; vb[4] = 32'h40000000; vr[4] = 32'h7F800000; vf[4] = 4'b0101;
    va[5] = 32'h00800000; vb[5] = 32'h00800000; vr[5] = 32'h00000000; vf[5] = 4'b0011;
    va[6] = 32'h7F800000; vb[6] = 32'h00000000; vr[6] = 32'h7FC00000; vf[6] = 4'b1000;
    va[7] = 32'h7FC00001; vb[7] = 32'h3F800000; vr[7] = 32'h7FC00000; vf[7] = 4'b0000;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; exp_in = '0;
    in_valid_h = 1'b0; out_ready_h = 1'b1; a_h = '0; b_h = '0; exp_h = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 36'(out_valid), 36'd0);
    chk("rst_result", 36'(result), 36'd0);
    chk("rst_flags", 36'(flags), 36'd0);
    chk("rst_in_ready", 36'(in_ready), 36'd1);
    chk("rst_out_valid_h", 36'(out_valid_h), 36'd0);

    // Single op: latency from the accepting edge
    send(va[0], vb[0], {vf[0], vr[0]});
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 36'(lat), 36'd3);

    for (int i = 1; i < 8; i++) send(va[i], vb[i], {vf[i], vr[i]});
    drain();

    // Six back-to-back ops with a five-cycle output stall once the first result is up
    fork
      for (int i = 1; i < 7; i++) send(va[i], vb[i], {vf[i], vr[i]});
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = result;
        chk("stall_first", 36'(held), 36'(vr[1]));
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_valid", 36'(out_valid), 36'd1);
          chk("stall_hold", 36'(result), 36'(held));
          chk("stall_in_ready", 36'(in_ready), 36'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight and a fresh op offered on the reset edge
    for (int i = 4; i < 7; i++) send(va[i], vb[i], {vf[i], vr[i]});
    rst = 1'b1;
    in_valid = 1'b1;
    a = va[0]; b = vb[0]; exp_in = {vf[0], vr[0]};
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rstmid_out_valid", 36'(out_valid), 36'd0);
    chk("rstmid_result", 36'(result), 36'd0);
    chk("rstmid_flags", 36'(flags), 36'd0);
    chk("rstmid_in_ready", 36'(in_ready), 36'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("rstmid_flushed", 36'(out_valid), 36'd0);
    end
    send(va[3], vb[3], {vf[3], vr[3]});
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency_after_rst", 36'(lat), 36'd3);
    drain();

    // Half precision
    in_valid_h = 1'b1;
    a_h = 16'h4200; b_h = 16'h4500; exp_h = {4'b0000, 16'h4B80};
    @(posedge clk);
    #1;
    a_h = 16'h7BFF; b_h = 16'h4000; exp_h = {4'b0101, 16'h7C00};
    @(posedge clk);
    #1;
    in_valid_h = 1'b0;
    drain();

    chk("outputs32", 36'(n_out), 36'd15);
    chk("outputs16", 36'(n_out_h), 36'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, pipelined floating-point multiplier for the SNN datapath, successor to the single-format unpipelined multiplier. It supports configurable exponent and mantissa widths and a valid/ready handshake with backpressure. It applies round-to-nearest-even, full special-value handling, and reports IEEE-style exception flags. It sits between the synaptic weight fetch and the membrane-potential accumulator, and its throughput is one product per clock.

## Interface
- EXP_W, 8: exponent width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored mantissa (fraction) width, without the hidden bit.
- W (derived, not overridable): 1+EXP_W+MAN_W, the operand and result width.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  W  operand A, {sign, exp, frac}.
- b  input  W  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  W  product.
- flags  output  4  {invalid, overflow, underflow, inexact}, aligned with result.

## Operation
- Sign is a.sign ^ b.sign for all non-NaN results.
- Operand classes:
  - zero/denormal: exp==0, flushed to zero and never raises a flag by itself.
  - inf: exp all-ones, frac==0.
  - NaN: exp all-ones, frac!=0.
  - normal: everything else.
- Special results, in priority order:
  - either operand NaN, or inf×zero: canonical qNaN {0, all-ones, 1 followed by MAN_W-1 zeros}. invalid=1 only for inf×zero; NaN inputs raise no flag.
  - inf×(inf or normal): signed inf, no flags.
  - zero×(zero or normal): signed zero, no flags.
- Normal×normal:
  - Product P = {1,fa}×{1,fb}, 2·MAN_W+2 bits unsigned.
  - Exponent e = ea+eb-bias, computed signed with EXP_W+2 bits.
  - If the MSB of P is set, shift right by 1 and e+1.
  - Keep MAN_W fraction bits, guard bit = next bit, sticky = OR of the remaining bits.
  - RNE: increment when guard & (sticky | lsb). If rounding carries out, renormalise and e+1.
  - inexact = guard | sticky.
  - e ≥ 2^EXP_W-1: signed inf, overflow=1, inexact=1.
  - e ≤ 0: signed zero, underflow=1, inexact=1. No denormal outputs.
- Pipeline stages:
  - S1: unpack, classify, exponent sum, mantissa multiply.
  - S2: normalise, round.
  - S3: overflow/underflow check, special-case select, pack into the output register.
- Each stage holds a valid bit. Data registers load only when the pipeline enable is high.

## Timing
- Latency: 3 cycles. Operands accepted on edge N appear with out_valid=1 after edge N+3, provided there is no stall.
- Pipeline enable en = !out_valid | out_ready. The whole pipeline advances together or freezes together; internal bubbles do not collapse.
- in_ready = en, which is combinational from out_valid and out_ready.
- A transfer occurs on a clock edge where valid & ready are both high.
- While out_valid=1 and out_ready=0, result and flags hold stable, and every stage keeps its contents.
- in_valid=1 with in_ready=0: the operands are not captured. The source must hold them.
- Simultaneous output drain and input accept in the same cycle is allowed, giving full throughput of 1 op/clk.
- Reset: on an edge with rst=1, all stage valid bits clear, out_valid=0, result=0 and flags=0 from the next cycle. In-flight operations are discarded. in_ready=1 from the next cycle.
- rst has priority over in_valid on the same edge.

## Test plan
- Default widths, no stall:
  - 0x4048F5C3×0x40A00000 → 0x417B3334, flags=0001 after 3 cycles.
  - 0x4048F5C3×0xC0A00000 → 0xC17B3334, flags=0001.
  - 0xC048F5C3×0xC0A00000 → 0x417B3334, flags=0001.
- RNE tie and specials:
  - 0x3F800001×0x3FC00000 → 0x3FC00002, flags=0001.
  - 0x7F000000×0x40000000 → 0x7F800000, flags=0101.
  - 0x00800000×0x00800000 → 0x00000000, flags=0011.
  - 0x7F800000×0x00000000 → 0x7FC00000, flags=1000.
  - 0x7FC00001×0x3F800000 → 0x7FC00000, flags=0000.
- Backpressure:
  - Stream 6 back-to-back ops, hold out_ready=0 for 5 cycles mid-stream.
  - Required: all 6 results delivered in order with none lost or duplicated.
  - Required: result stable while stalled, in_ready=0 during the stall.
- Reset mid-operation:
  - Assert rst for 1 cycle with 3 ops in flight.
  - Required: out_valid=0 and result=0 the next cycle, none of the 3 results ever emerges, and a new op afterwards completes in 3 cycles.
- EXP_W=5, MAN_W=10 (half precision):
  - 0x4200×0x4500 (3.0×5.0) → 0x4B80, flags=0000.
  - 0x7BFF×0x4000 → 0x7C00, flags=0101.
